// File: rtl/pfr_led_display_mux_if.sv
// Front-panel display bus: pass-through sources, PFR sources and board-side outputs.
// The display mux is the slave; the environment driving the inputs is the master.
interface pfr_led_display_mux_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    i1mSCE;
  logic [7:0]              pass_led;
  logic [NUM_DIGITS-1:0]   pass_sel_n;
  logic                    pass_postled_sel;
  logic                    pfr_owns_display;
  logic [4*NUM_DIGITS-1:0] pfr_digit_data;
  logic [7:0]              pfr_postled;
  logic                    pfr_blink_en;
  logic [7:0]              led_control;
  logic [NUM_DIGITS-1:0]   digit_sel_n;
  logic                    postled_sel;
  logic                    owner;

  modport master (
    output i1mSCE, pass_led, pass_sel_n, pass_postled_sel,
    output pfr_owns_display, pfr_digit_data, pfr_postled, pfr_blink_en,
    input  led_control, digit_sel_n, postled_sel, owner
  );

  modport slave (
    input  i1mSCE, pass_led, pass_sel_n, pass_postled_sel,
    input  pfr_owns_display, pfr_digit_data, pfr_postled, pfr_blink_en,
    output led_control, digit_sel_n, postled_sel, owner
  );
endinterface

// File: rtl/pfr_led_display_mux.sv
// Front-panel display mux: common-core pass-through or PFR-driven 7-seg/POST-LED scan,
// with blank-out drain on every ownership change and break-before-make between slots.
module pfr_led_display_mux #(
  parameter int NUM_DIGITS  = 2,
  parameter int DWELL_TICKS = 4,
  parameter int BLINK_TICKS = 500
) (
  input logic                  clk,
  input logic                  resetn,
  pfr_led_display_mux_if.slave bus
);

  localparam int SW = $clog2(NUM_DIGITS + 1);
  localparam logic [7:0]    DW_LAST = 8'(DWELL_TICKS - 1);
  localparam logic [9:0]    BL_LAST = 10'(BLINK_TICKS - 1);
  localparam logic [SW-1:0] POST_SLOT = SW'(NUM_DIGITS);

  typedef enum logic [1:0] {
    PASS,
    DRAIN,
    SCAN_GAP,
    SCAN_SHOW
  } state_e;

  state_e                state_q, state_d;
  logic                  tgt_q, tgt_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic                  owner_q, owner_d;
  logic [9:0]            blk_cnt_q, blk_cnt_d;
  logic                  blk_on_q, blk_on_d;
  logic                  blk_en_q;
  logic [7:0]            led_q, led_d;
  logic [NUM_DIGITS-1:0] sel_n_q, sel_n_d;
  logic                  post_q, post_d;
  logic                  dw_done;
  logic                  blk_rise;
  logic [3:0]            nib;

  function automatic logic [7:0] seg7(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= PASS;
      tgt_q     <= 1'b0;
      cnt_q     <= '0;
      slot_q    <= '0;
      owner_q   <= 1'b0;
      blk_cnt_q <= '0;
      blk_on_q  <= 1'b1;
      blk_en_q  <= 1'b0;
      led_q     <= 8'hFF;
      sel_n_q   <= '1;
      post_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      owner_q   <= owner_d;
      blk_cnt_q <= blk_cnt_d;
      blk_on_q  <= blk_on_d;
      blk_en_q  <= bus.pfr_blink_en;
      led_q     <= led_d;
      sel_n_q   <= sel_n_d;
      post_q    <= post_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    owner_d = owner_q;
    dw_done = bus.i1mSCE && (cnt_q == DW_LAST);
    unique case (state_q)
      PASS: begin
        if (bus.pfr_owns_display) begin
          state_d = DRAIN;
          tgt_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        // A request change restarts the whole drain toward the new target
        if (bus.pfr_owns_display != tgt_q) begin
          tgt_d = bus.pfr_owns_display;
          cnt_d = '0;
        end else if (dw_done) begin
          cnt_d   = '0;
          slot_d  = '0;
          owner_d = tgt_q;
          state_d = tgt_q ? SCAN_GAP : PASS;
        end else if (bus.i1mSCE) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SCAN_GAP: begin
        if (!bus.pfr_owns_display) begin
          state_d = DRAIN;
          tgt_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = SCAN_SHOW;
        end
      end
      SCAN_SHOW: begin
        if (!bus.pfr_owns_display) begin
          state_d = DRAIN;
          tgt_d   = 1'b0;
          cnt_d   = '0;
        end else if (dw_done) begin
          cnt_d   = '0;
          slot_d  = (slot_q == POST_SLOT) ? '0 : slot_q + SW'(1);
          state_d = SCAN_GAP;
        end else if (bus.i1mSCE) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = PASS;
    endcase

    blk_rise  = bus.pfr_blink_en && !blk_en_q;
    blk_cnt_d = blk_cnt_q;
    blk_on_d  = blk_on_q;
    if (blk_rise) begin
      blk_cnt_d = '0;
      blk_on_d  = 1'b1;
    end else if (bus.i1mSCE) begin
      if (blk_cnt_q == BL_LAST) begin
        blk_cnt_d = '0;
        blk_on_d  = !blk_on_q;
      end else begin
        blk_cnt_d = blk_cnt_q + 10'd1;
      end
    end
  end

  // Outputs follow the next state so selects drop on the very edge that leaves a slot
  always_comb begin
    led_d   = led_q;
    sel_n_d = '1;
    post_d  = 1'b0;
    nib     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot_d == SW'(k)) nib = bus.pfr_digit_data[4*k +: 4];
    end
    unique case (state_d)
      PASS: begin
        led_d   = bus.pass_led;
        sel_n_d = bus.pass_sel_n;
        post_d  = bus.pass_postled_sel;
      end
      DRAIN: led_d = 8'hFF;
      SCAN_GAP: begin
        led_d = (slot_d == POST_SLOT) ? bus.pfr_postled : seg7(nib);
      end
      SCAN_SHOW: begin
        if (slot_d == POST_SLOT) begin
          post_d = 1'b1;
        end else if (blk_on_d || !bus.pfr_blink_en) begin
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (slot_d == SW'(k)) sel_n_d[k] = 1'b0;
          end
        end
      end
      default: led_d = 8'hFF;
    endcase
  end

  assign bus.led_control = led_q;
  assign bus.digit_sel_n = sel_n_q;
  assign bus.postled_sel = post_q;
  assign bus.owner       = owner_q;

endmodule

// File: tb/tb_pfr_led_display_mux.sv
// Directed bench for pfr_led_display_mux: pass-through, claim/drain, scan wrap,
// drain restart, release priority, blink and asynchronous reset.
module tb_pfr_led_display_mux;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic [2:0] act, prev_act = '0;

  pfr_led_display_mux_if #(.NUM_DIGITS(2)) bus ();

  pfr_led_display_mux #(
    .NUM_DIGITS (2),
    .DWELL_TICKS(4),
    .BLINK_TICKS(3)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic ms();
    bus.i1mSCE = 1'b1;
    tick_clk();
    bus.i1mSCE = 1'b0;
  endtask

  task automatic ms_n(input int n);
    for (int i = 0; i < n; i++) ms();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] led,
                         input logic [1:0] sel, input logic post, input logic own);
    chk({tag, ".led"}, {24'd0, bus.led_control}, {24'd0, led});
    chk({tag, ".sel"}, {30'd0, bus.digit_sel_n}, {30'd0, sel});
    chk({tag, ".post"}, {31'd0, bus.postled_sel}, {31'd0, post});
    chk({tag, ".owner"}, {31'd0, bus.owner}, {31'd0, own});
  endtask

  // One-hot select and break-before-make monitor while PFR is involved
  always @(negedge clk) begin
    if (mon_en) begin
      act = {bus.postled_sel, ~bus.digit_sel_n};
      checks++;
      assert ($countones(act) <= 1 &&
              !(act != 3'b0 && prev_act != 3'b0 && act != prev_act)) else begin
        errors++;
        $error("FAIL onehot_bbm: observed %b after %b expected single select with gap",
               act, prev_act);
      end
      prev_act = act;
    end else begin
      prev_act = '0;
    end
  end

  initial begin
    bus.i1mSCE = 1'b0;
    bus.pass_led = 8'hC3;
    bus.pass_sel_n = 2'b11;
    bus.pass_postled_sel = 1'b0;
    bus.pfr_owns_display = 1'b0;
    bus.pfr_digit_data = 8'h3A;
    bus.pfr_postled = 8'h0F;
    bus.pfr_blink_en = 1'b0;

    tick_clk();
    tick_clk();
    chk_out("reset", 8'hFF, 2'b11, 1'b0, 1'b0);
    resetn = 1'b1;
    tick_clk();
    chk_out("pass_c3", 8'hC3, 2'b11, 1'b0, 1'b0);

    bus.pass_led = 8'h5A;
    bus.pass_sel_n = 2'b10;
    bus.pass_postled_sel = 1'b1;
    chk("pass_latency", {24'd0, bus.led_control}, 32'hC3);
    tick_clk();
    chk_out("pass_5a", 8'h5A, 2'b10, 1'b1, 1'b0);

    bus.pass_sel_n = 2'b11;
    bus.pass_postled_sel = 1'b0;
    bus.pfr_owns_display = 1'b1;
    tick_clk();
    mon_en = 1'b1;
    chk_out("drain0", 8'hFF, 2'b11, 1'b0, 1'b0);
    ms_n(3);
    tick_clk();
    chk_out("drain3", 8'hFF, 2'b11, 1'b0, 1'b0);
    ms();
    chk_out("gap0", 8'h88, 2'b11, 1'b0, 1'b1);
    tick_clk();
    chk_out("show0", 8'h88, 2'b10, 1'b0, 1'b1);
    tick_clk();
    chk_out("show0_hold", 8'h88, 2'b10, 1'b0, 1'b1);

    ms_n(4);
    chk_out("gap1", 8'hB0, 2'b11, 1'b0, 1'b1);
    tick_clk();
    chk_out("show1", 8'hB0, 2'b01, 1'b0, 1'b1);
    ms_n(4);
    chk_out("gap_post", 8'h0F, 2'b11, 1'b0, 1'b1);
    tick_clk();
    chk_out("show_post", 8'h0F, 2'b11, 1'b1, 1'b1);
    ms_n(4);
    chk_out("gap_wrap", 8'h88, 2'b11, 1'b0, 1'b1);
    tick_clk();
    chk_out("show_wrap", 8'h88, 2'b10, 1'b0, 1'b1);
    bus.pfr_digit_data = 8'h35;
    tick_clk();
    chk_out("no_tear", 8'h88, 2'b10, 1'b0, 1'b1);

    bus.pfr_owns_display = 1'b0;
    tick_clk();
    chk_out("release", 8'hFF, 2'b11, 1'b0, 1'b1);
    bus.pass_led = 8'h5A;
    ms_n(4);
    chk_out("back_pass", 8'h5A, 2'b11, 1'b0, 1'b0);

    bus.pfr_owns_display = 1'b1;
    tick_clk();
    ms_n(2);
    bus.pfr_owns_display = 1'b0;
    tick_clk();
    bus.pfr_owns_display = 1'b1;
    tick_clk();
    chk_out("restart", 8'hFF, 2'b11, 1'b0, 1'b0);
    ms_n(3);
    chk_out("restart3", 8'hFF, 2'b11, 1'b0, 1'b0);
    ms();
    chk_out("restart_gap", 8'h92, 2'b11, 1'b0, 1'b1);
    tick_clk();
    chk_out("restart_show", 8'h92, 2'b10, 1'b0, 1'b1);

    ms_n(3);
    bus.pfr_owns_display = 1'b0;
    ms();
    chk_out("release_wins", 8'hFF, 2'b11, 1'b0, 1'b1);
    ms_n(4);
    chk_out("pass_again", 8'h5A, 2'b11, 1'b0, 1'b0);

    bus.pfr_owns_display = 1'b1;
    tick_clk();
    ms_n(4);
    tick_clk();
    chk_out("blink_pre", 8'h92, 2'b10, 1'b0, 1'b1);
    bus.pfr_blink_en = 1'b1;
    tick_clk();
    chk_out("blink_rise", 8'h92, 2'b10, 1'b0, 1'b1);
    ms_n(2);
    chk_out("blink_on", 8'h92, 2'b10, 1'b0, 1'b1);
    ms();
    chk_out("blink_off", 8'h92, 2'b11, 1'b0, 1'b1);
    ms();
    chk_out("blink_gap1", 8'hB0, 2'b11, 1'b0, 1'b1);
    tick_clk();
    chk_out("blink_off1", 8'hB0, 2'b11, 1'b0, 1'b1);
    ms_n(2);
    chk_out("blink_on1", 8'hB0, 2'b01, 1'b0, 1'b1);
    ms_n(2);
    tick_clk();
    chk_out("blink_post", 8'h0F, 2'b11, 1'b1, 1'b1);
    ms();
    chk_out("blink_post_off", 8'h0F, 2'b11, 1'b1, 1'b1);
    ms_n(3);
    tick_clk();
    chk_out("blink_show0", 8'h92, 2'b10, 1'b0, 1'b1);

    mon_en = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk_out("async_reset", 8'hFF, 2'b11, 1'b0, 1'b0);
    bus.pfr_owns_display = 1'b0;
    bus.pfr_blink_en = 1'b0;
    tick_clk();
    resetn = 1'b1;
    tick_clk();
    chk_out("post_reset", 8'h5A, 2'b11, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
